axi4_mem_responder: RTL and testbench

AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

---
 rtl/axi4_mem_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi4_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a RAM with one write port and one registered read port; independent write/read FSMs.
// Optional byte-masked writes: define AXI4_MEM_RESPONDER_WSTRB_EN.
module axi4_mem_responder #(
    parameter int id_width_p   = 6,
    parameter int addr_width_p = 64,
    parameter int data_width_p = 512,
    parameter int mem_els_p    = 1024,
    localparam int mosi_w_lp   = 2*(id_width_p+addr_width_p+31) + data_width_p + data_width_p/8 + 5,
    localparam int miso_w_lp   = 2*id_width_p + data_width_p + 12
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [mosi_w_lp-1:0] s_axi4_i,
    output logic [miso_w_lp-1:0] s_axi4_o
);
    localparam int bytes_lp  = data_width_p/8;
    localparam int shift_lp  = $clog2(bytes_lp);
    localparam int mem_aw_lp = $clog2(mem_els_p);
    localparam logic [addr_width_p-1:0] step_lp    = addr_width_p'(bytes_lp);
    localparam logic [addr_width_p-1:0] mem_els_lp = addr_width_p'(mem_els_p);
    localparam logic [1:0] BURST_FIXED = 2'b00, BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [id_width_p-1:0]   awid;
        logic [addr_width_p-1:0] awaddr;
        logic [7:0]              awlen;
        logic [2:0]              awsize;
        logic [1:0]              awburst;
        logic                    awlock;
        logic [3:0]              awcache;
        logic [2:0]              awprot;
        logic [3:0]              awqos;
        logic [3:0]              awregion;
        logic                    awuser;
        logic                    awvalid;
        logic [data_width_p-1:0] wdata;
        logic [bytes_lp-1:0]     wstrb;
        logic                    wlast;
        logic                    wuser;
        logic                    wvalid;
        logic                    bready;
        logic [id_width_p-1:0]   arid;
        logic [addr_width_p-1:0] araddr;
        logic [7:0]              arlen;
        logic [2:0]              arsize;
        logic [1:0]              arburst;
        logic                    arlock;
        logic [3:0]              arcache;
        logic [2:0]              arprot;
        logic [3:0]              arqos;
        logic [3:0]              arregion;
        logic                    aruser;
        logic                    arvalid;
        logic                    rready;
    } mosi_s;

    typedef struct packed {
        logic                    awready;
        logic                    wready;
        logic [id_width_p-1:0]   bid;
        logic [1:0]              bresp;
        logic                    buser;
        logic                    bvalid;
        logic                    arready;
        logic [id_width_p-1:0]   rid;
        logic [data_width_p-1:0] rdata;
        logic [1:0]              rresp;
        logic                    rlast;
        logic                    ruser;
        logic                    rvalid;
    } miso_s;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    mosi_s req;
    miso_s rsp;
    assign req = s_axi4_i;
    assign s_axi4_o = rsp;

    w_state_e w_state_r, w_state_n;
    r_state_e r_state_r, r_state_n;
    logic awready, wready, bvalid, arready, rvalid;

    logic [data_width_p-1:0] mem_r [mem_els_p];

    logic [id_width_p-1:0]   bid_r, rid_r;
    logic [addr_width_p-1:0] waddr_r, raddr_r, r_addr_n, w_idx, r_idx_n;
    logic [7:0]              wlen_r, wcnt_r, rlen_r, rcnt_r;
    logic [1:0]              wburst_r, rburst_r, r_burst_n, rresp_r;
    logic                    wsize_ok_r, rsize_ok_r, r_size_ok_n;
    logic                    wover_r, wslv_r, wdec_r, rlast_r;
    logic [data_width_p-1:0] rdata_r;
    logic aw_hs, w_beat, w_slv, w_dec, w_we, ar_hs, r_hs, r_load, r_slv_n, r_dec_n;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
        end else begin
            w_state_r <= w_state_n;
            r_state_r <= r_state_n;
        end
    end

    // Ready/valid come straight from state; reset gates the IDLE readies low.
    always_comb begin
        w_state_n = w_state_r;
        r_state_n = r_state_r;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        arready = 1'b0; rvalid = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                awready = !reset_i;
                if (req.awvalid && !reset_i) w_state_n = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (req.wvalid && req.wlast) w_state_n = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (req.bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
        case (r_state_r)
            R_IDLE: begin
                arready = !reset_i;
                if (req.arvalid && !reset_i) r_state_n = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (req.rready && rlast_r) r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // Write beat classification; DECERR takes priority over SLVERR in bresp.
    assign aw_hs  = awready && req.awvalid;
    assign w_beat = wready && req.wvalid;
    assign w_idx  = waddr_r >> shift_lp;
    assign w_dec  = w_idx >= mem_els_lp;
    assign w_slv  = !wsize_ok_r || wburst_r == BURST_WRAP || wover_r || (req.wlast && wcnt_r != wlen_r);
    assign w_we   = w_beat && !w_dec && !w_slv;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bid_r <= '0; waddr_r <= '0; wlen_r <= '0; wcnt_r <= '0; wburst_r <= '0;
            wsize_ok_r <= 1'b0; wover_r <= 1'b0; wslv_r <= 1'b0; wdec_r <= 1'b0;
        end else if (aw_hs) begin
            bid_r      <= req.awid;
            waddr_r    <= req.awaddr;
            wlen_r     <= req.awlen;
            wburst_r   <= req.awburst;
            wsize_ok_r <= req.awsize == 3'(shift_lp);
            wcnt_r     <= '0;
            wover_r    <= 1'b0;
            wslv_r     <= 1'b0;
            wdec_r     <= 1'b0;
        end else if (w_beat) begin
            wcnt_r  <= wcnt_r + 8'd1;
            // Beat awlen without wlast makes the burst long: every later beat is an error.
            wover_r <= wover_r || (!req.wlast && wcnt_r == wlen_r);
            wslv_r  <= wslv_r || w_slv;
            wdec_r  <= wdec_r || w_dec;
            if (wburst_r != BURST_FIXED) waddr_r <= waddr_r + step_lp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we) begin
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
            for (int b = 0; b < bytes_lp; b++)
                if (req.wstrb[b]) mem_r[w_idx[mem_aw_lp-1:0]][8*b +: 8] <= req.wdata[8*b +: 8];
`else
            mem_r[w_idx[mem_aw_lp-1:0]] <= req.wdata;
`endif
        end
    end

    // The RAM is read on the cycle a beat is launched, so rdata is registered for the next cycle.
    assign ar_hs  = arready && req.arvalid;
    assign r_hs   = rvalid && req.rready;
    assign r_load = ar_hs || (r_hs && !rlast_r);

    always_comb begin
        r_addr_n    = raddr_r;
        r_size_ok_n = rsize_ok_r;
        r_burst_n   = rburst_r;
        if (ar_hs) begin
            r_addr_n    = req.araddr;
            r_size_ok_n = req.arsize == 3'(shift_lp);
            r_burst_n   = req.arburst;
        end else if (rburst_r != BURST_FIXED) begin
            r_addr_n = raddr_r + step_lp;
        end
    end

    assign r_idx_n = r_addr_n >> shift_lp;
    assign r_dec_n = r_idx_n >= mem_els_lp;
    assign r_slv_n = !r_size_ok_n || r_burst_n == BURST_WRAP;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            raddr_r <= '0; rsize_ok_r <= 1'b0; rburst_r <= '0; rdata_r <= '0; rresp_r <= '0;
            rid_r <= '0; rlen_r <= '0; rcnt_r <= '0; rlast_r <= 1'b0;
        end else if (r_load) begin
            raddr_r    <= r_addr_n;
            rsize_ok_r <= r_size_ok_n;
            rburst_r   <= r_burst_n;
            rdata_r    <= (r_dec_n || r_slv_n) ? '0 : mem_r[r_idx_n[mem_aw_lp-1:0]];
            rresp_r    <= r_dec_n ? RESP_DECERR : (r_slv_n ? RESP_SLVERR : RESP_OKAY);
            if (ar_hs) begin
                rid_r   <= req.arid;
                rlen_r  <= req.arlen;
                rcnt_r  <= '0;
                rlast_r <= req.arlen == 8'd0;
            end else begin
                rcnt_r  <= rcnt_r + 8'd1;
                rlast_r <= (rcnt_r + 8'd1) == rlen_r;
            end
        end
    end

    always_comb begin
        rsp         = '0;
        rsp.awready = awready;
        rsp.wready  = wready;
        rsp.bid     = bid_r;
        rsp.bresp   = wdec_r ? RESP_DECERR : (wslv_r ? RESP_SLVERR : RESP_OKAY);
        rsp.bvalid  = bvalid;
        rsp.arready = arready;
        rsp.rid     = rid_r;
        rsp.rdata   = rdata_r;
        rsp.rresp   = rresp_r;
        rsp.rlast   = rlast_r;
        rsp.rvalid  = rvalid;
    end

    logic unused_bits;
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
    assign unused_bits = ^{req.awlock, req.awcache, req.awprot, req.awqos, req.awregion, req.awuser,
                           req.wuser, req.arlock, req.arcache, req.arprot, req.arqos, req.arregion, req.aruser};
`else
    assign unused_bits = ^{req.awlock, req.awcache, req.awprot, req.awqos, req.awregion, req.awuser,
                           req.wuser, req.arlock, req.arcache, req.arprot, req.arqos, req.arregion, req.aruser,
                           req.wstrb};
`endif

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed self-checking bench for axi4_mem_responder (default 512-bit data, 1024-word RAM).
module tb_axi4_mem_responder;
    localparam int ID_W = 6, AW = 64, DW = 512, ELS = 1024;
    localparam int MOSI_W = 2*(ID_W+AW+31) + DW + DW/8 + 5;
    localparam int MISO_W = 2*ID_W + DW + 12;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    typedef struct packed {
        logic [ID_W-1:0] awid; logic [AW-1:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
        logic [1:0] awburst; logic awlock; logic [3:0] awcache; logic [2:0] awprot; logic [3:0] awqos;
        logic [3:0] awregion; logic awuser; logic awvalid;
        logic [DW-1:0] wdata; logic [DW/8-1:0] wstrb; logic wlast; logic wuser; logic wvalid;
        logic bready;
        logic [ID_W-1:0] arid; logic [AW-1:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
        logic [1:0] arburst; logic arlock; logic [3:0] arcache; logic [2:0] arprot; logic [3:0] arqos;
        logic [3:0] arregion; logic aruser; logic arvalid;
        logic rready;
    } mosi_s;

    typedef struct packed {
        logic awready; logic wready; logic [ID_W-1:0] bid; logic [1:0] bresp; logic buser; logic bvalid;
        logic arready; logic [ID_W-1:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp; logic rlast;
        logic ruser; logic rvalid;
    } miso_s;

    logic clk = 1'b0;
    logic reset_i;
    mosi_s req;
    logic [MISO_W-1:0] rsp_raw;
    miso_s rsp;
    assign rsp = rsp_raw;

    int n_cmp = 0;
    int n_err = 0;

    axi4_mem_responder #(.id_width_p(ID_W), .addr_width_p(AW), .data_width_p(DW), .mem_els_p(ELS)) dut (
        .clk_i(clk), .reset_i(reset_i), .s_axi4_i(req), .s_axi4_o(rsp_raw));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input logic [DW-1:0] d0, input logic [DW/8-1:0] strb, input logic [1:0] exp_resp);
        @(negedge clk);
        chk("awready", 512'(rsp.awready), 512'd1);
        req.awvalid = 1'b1; req.awid = id; req.awaddr = addr; req.awlen = len;
        req.awsize = size; req.awburst = burst;
        @(negedge clk);
        req.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            chk("wready", 512'(rsp.wready), 512'd1);
            req.wvalid = 1'b1; req.wdata = d0 + 512'(i); req.wstrb = strb; req.wlast = (i == nbeats-1);
            @(negedge clk);
        end
        req.wvalid = 1'b0; req.wlast = 1'b0;
        chk("bvalid", 512'(rsp.bvalid), 512'd1);
        chk("bid", 512'(rsp.bid), 512'(id));
        chk("bresp", 512'(rsp.bresp), 512'(exp_resp));
        req.bready = 1'b1;
        @(negedge clk);
        req.bready = 1'b0;
        chk("bvalid_clr", 512'(rsp.bvalid), 512'd0);
        chk("awready_ret", 512'(rsp.awready), 512'd1);
    endtask

    // Beats below split expect resp_a, the rest resp_b; error beats expect zero data.
    task automatic rd_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                            input logic [DW-1:0] d0, input int split, input logic [1:0] resp_a,
                            input logic [1:0] resp_b);
        int b, cyc;
        logic [1:0] er;
        logic acc;
        b = 0; cyc = 0;
        @(negedge clk);
        chk("arready", 512'(rsp.arready), 512'd1);
        req.arvalid = 1'b1; req.arid = id; req.araddr = addr; req.arlen = len;
        req.arsize = size; req.arburst = burst;
        @(negedge clk);
        req.arvalid = 1'b0;
        while (b <= int'(len) && cyc < 64) begin
            er = (b < split) ? resp_a : resp_b;
            chk("rvalid", 512'(rsp.rvalid), 512'd1);
            chk("rdata", rsp.rdata, (er == 2'b00) ? d0 + 512'(b) : 512'd0);
            chk("rid", 512'(rsp.rid), 512'(id));
            chk("rresp", 512'(rsp.rresp), 512'(er));
            chk("rlast", 512'(rsp.rlast), 512'(b == int'(len)));
            req.rready = toggle ? (cyc % 2 == 1) : 1'b1;
            acc = rsp.rvalid && req.rready;
            @(negedge clk);
            if (acc) b++;
            cyc++;
        end
        req.rready = 1'b0;
        chk("r_beats", 512'(b), 512'(int'(len) + 1));
        chk("rvalid_clr", 512'(rsp.rvalid), 512'd0);
        chk("arready_ret", 512'(rsp.arready), 512'd1);
    endtask

    initial begin
        req = '0;
        reset_i = 1'b1;
        @(negedge clk);
        chk("rst_awready", 512'(rsp.awready), 512'd0);
        chk("rst_wready", 512'(rsp.wready), 512'd0);
        chk("rst_bvalid", 512'(rsp.bvalid), 512'd0);
        chk("rst_arready", 512'(rsp.arready), 512'd0);
        chk("rst_rvalid", 512'(rsp.rvalid), 512'd0);
        chk("rst_bid_bresp", 512'({rsp.bid, rsp.bresp}), 512'd0);
        chk("rst_rid_rresp_rlast", 512'({rsp.rid, rsp.rresp, rsp.rlast}), 512'd0);
        chk("rst_rdata", rsp.rdata, 512'd0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", 512'(rsp.awready), 512'd1);
        chk("post_rst_arready", 512'(rsp.arready), 512'd1);

        // Basic 4-beat INCR write then readback.
        wr_burst(6'd3, 64'h40, 8'd3, 3'd6, INCR, 4, 512'hA, '1, 2'b00);
        rd_burst(6'd3, 64'h40, 8'd3, 3'd6, INCR, 1'b0, 512'hA, 99, 2'b00, 2'b00);

        // 8-beat read with rready toggling.
        wr_burst(6'd1, 64'h400, 8'd7, 3'd6, INCR, 8, 512'h100, '1, 2'b00);
        rd_burst(6'd5, 64'h400, 8'd7, 3'd6, INCR, 1'b1, 512'h100, 99, 2'b00, 2'b00);

        // Short burst: beat 0 lands, the early-wlast beat does not.
        wr_burst(6'd2, 64'h800, 8'd3, 3'd6, INCR, 2, 512'h200, '1, 2'b10);
        rd_burst(6'd2, 64'h800, 8'd0, 3'd6, INCR, 1'b0, 512'h200, 99, 2'b00, 2'b00);

        // Out-of-range and protocol errors.
        rd_burst(6'd4, 64'h10000, 8'd0, 3'd6, INCR, 1'b0, 512'd0, 0, 2'b00, 2'b11);
        wr_burst(6'd6, 64'h10000, 8'd0, 3'd6, INCR, 1, 512'h1, '1, 2'b11);
        wr_burst(6'd7, 64'hA00, 8'd1, 3'd6, WRAP, 2, 512'h300, '1, 2'b10);
        rd_burst(6'd8, 64'h40, 8'd0, 3'd2, INCR, 1'b0, 512'd0, 0, 2'b00, 2'b10);

        // Last word is fine, the next beat runs off the end of the RAM.
        wr_burst(6'd9, 64'hFFC0, 8'd0, 3'd6, INCR, 1, 512'h55, '1, 2'b00);
        rd_burst(6'd9, 64'hFFC0, 8'd1, 3'd6, INCR, 1'b0, 512'h55, 1, 2'b00, 2'b11);

        // FIXED read re-reads the same word.
        rd_burst(6'd11, 64'h40, 8'd0, 3'd6, FIXED, 1'b0, 512'hA, 99, 2'b00, 2'b00);

        // Byte strobes.
        wr_burst(6'd12, 64'hC00, 8'd0, 3'd6, INCR, 1, {DW{1'b1}}, '1, 2'b00);
        wr_burst(6'd12, 64'hC00, 8'd0, 3'd6, INCR, 1, 512'd0, 64'h1, 2'b00);
`ifdef AXI4_MEM_RESPONDER_WSTRB_EN
        rd_burst(6'd12, 64'hC00, 8'd0, 3'd6, INCR, 1'b0, {{(DW/8-1){8'hFF}}, 8'h00}, 99, 2'b00, 2'b00);
`else
        rd_burst(6'd12, 64'hC00, 8'd0, 3'd6, INCR, 1'b0, 512'd0, 99, 2'b00, 2'b00);
`endif

        // Same-cycle write and read of one word returns the old data.
        wr_burst(6'd13, 64'hE00, 8'd0, 3'd6, INCR, 1, 512'h77, '1, 2'b00);
        @(negedge clk);
        req.awvalid = 1'b1; req.awid = 6'd13; req.awaddr = 64'hE00; req.awlen = 8'd0;
        req.awsize = 3'd6; req.awburst = INCR;
        @(negedge clk);
        req.awvalid = 1'b0;
        req.wvalid = 1'b1; req.wdata = 512'h88; req.wstrb = '1; req.wlast = 1'b1;
        req.arvalid = 1'b1; req.arid = 6'd14; req.araddr = 64'hE00; req.arlen = 8'd0;
        req.arsize = 3'd6; req.arburst = INCR;
        @(negedge clk);
        req.wvalid = 1'b0; req.wlast = 1'b0; req.arvalid = 1'b0;
        chk("rbw_rvalid", 512'(rsp.rvalid), 512'd1);
        chk("rbw_old", rsp.rdata, 512'h77);
        chk("rbw_bvalid", 512'(rsp.bvalid), 512'd1);
        req.rready = 1'b1; req.bready = 1'b1;
        @(negedge clk);
        req.rready = 1'b0; req.bready = 1'b0;
        rd_burst(6'd14, 64'hE00, 8'd0, 3'd6, INCR, 1'b0, 512'h88, 99, 2'b00, 2'b00);

        // Asynchronous reset during write beat 2 of 4.
        @(negedge clk);
        req.awvalid = 1'b1; req.awid = 6'd15; req.awaddr = 64'h1000; req.awlen = 8'd3;
        req.awsize = 3'd6; req.awburst = INCR;
        @(negedge clk);
        req.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req.wvalid = 1'b1; req.wdata = 512'(i); req.wlast = 1'b0;
            @(negedge clk);
        end
        req.wdata = 512'd2;
        chk("mid_wready", 512'(rsp.wready), 512'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_wready", 512'(rsp.wready), 512'd0);
        chk("arst_bvalid", 512'(rsp.bvalid), 512'd0);
        chk("arst_awready", 512'(rsp.awready), 512'd0);
        req = '0;
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("rel_awready", 512'(rsp.awready), 512'd1);
        for (int i = 0; i < 3; i++) begin
            chk("no_b", 512'({rsp.bvalid, rsp.wready}), 512'd0);
            @(negedge clk);
        end

        // Asynchronous reset mid read burst.
        req.arvalid = 1'b1; req.arid = 6'd16; req.araddr = 64'h40; req.arlen = 8'd3;
        req.arsize = 3'd6; req.arburst = INCR;
        @(negedge clk);
        req.arvalid = 1'b0; req.rready = 1'b1;
        @(negedge clk);
        req.rready = 1'b0;
        chk("mid_rdata", rsp.rdata, 512'hB);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_rvalid", 512'(rsp.rvalid), 512'd0);
        chk("arst_rdata", rsp.rdata, 512'd0);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("rel_arready", 512'(rsp.arready), 512'd1);
        chk("rel_rvalid", 512'(rsp.rvalid), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
